video_mode_tracker: RTL and testbench
=====================================

// Module: video_mode_tracker
// PURPOSE
//  Consumes the measured frame rate (o_freq/o_valid of the frame-rate counter) plus vsync and
//  decides a stable video mode class (NONE/50Hz/60Hz/OTHER) for the ADV7511 config sequencer.
//  Filters per-frame jitter with a stability counter and detects vsync loss with a watchdog.
//  Signals each committed mode change with a 4-phase req/ack handshake to the I2C config FSM.
// PARAMETERS
//  CLK_FREQ_IN    148  clock frequency in MHz; must match the frame-rate counter
//  STABLE_FRAMES  8    consecutive identical classifications required to commit a mode
//  TIMEOUT_MS     100  vsync-loss watchdog period in ms (cycles = CLK_FREQ_IN*1000*TIMEOUT_MS)
// PORTS
//  clk              in   1  system clock
//  reset            in   1  synchronous, active-high reset
//  i_vsync          in   1  raw vsync, asynchronous to clk, rising edge = frame start
//  i_freq           in   7  measured frame rate in Hz, 0 = unmeasurable
//  i_freq_valid     in   1  i_freq is meaningful
//  i_reconfig_ack   in   1  config sequencer acknowledge (4-phase)
//  o_mode           out  2  committed mode: 0 NONE, 1 HZ50, 2 HZ60, 3 OTHER
//  o_locked         out  1  o_mode != NONE and no change pending
//  o_reconfig_req   out  1  a new o_mode awaits reconfiguration; held until ack
// BEHAVIOUR
//  Reset: o_mode=NONE, o_locked=0, o_reconfig_req=0; FSM=SEARCH, candidate=NONE, count=0,
//   watchdog=0. Reset wins over every other event, including mid-handshake (req drops next edge).
//  Vsync: 2-flop synchroniser, rising edge = 01 on the sync pair. Evaluation strobe eval = edge
//   delayed 4 clk, so i_freq has already updated for the frame that just ended.
//  Classify at eval: !i_freq_valid or i_freq==0 -> NONE; 47..53 -> HZ50; 56..64 -> HZ60;
//   any other value -> OTHER. Window bounds are inclusive.
//  Stability: at eval, class==candidate -> count+1, saturating at STABLE_FRAMES;
//   otherwise candidate<=class, count<=1. stable = (count==STABLE_FRAMES).
//  Watchdog: counts clk cycles, cleared on every vsync edge. On reaching the timeout:
//   candidate<=NONE, count<=STABLE_FRAMES (immediately stable), watchdog holds at terminal value
//   until the next edge. The first edge after a timeout restarts normal counting.
//  FSM (one transition per clk):
//   SEARCH: o_mode==NONE. stable && candidate!=NONE -> o_mode<=candidate, REQ.
//   LOCKED: stable && candidate!=o_mode -> o_mode<=candidate, REQ.
//   REQ: o_reconfig_req=1; ack==1 -> ACK_LOW.
//   ACK_LOW: o_reconfig_req=0; ack==0 -> (o_mode==NONE ? SEARCH : LOCKED).
//   Entering SEARCH from LOCKED through a NONE commit also raises REQ (go REQ, then SEARCH).
//  o_locked=1 only in LOCKED. o_mode changes only on the clock that enters REQ, and is stable
//   for the whole REQ/ACK_LOW handshake.
//  A class change during REQ/ACK_LOW is still tracked by the stability counter; it is acted on
//   from LOCKED/SEARCH afterwards (at most one request outstanding).
//  eval coinciding with a watchdog timeout: the timeout wins.
//  ack already high when REQ is entered: REQ lasts exactly 1 cycle.
//  Widths: watchdog counter is $clog2(CLK_FREQ_IN*1000*TIMEOUT_MS)+1 bits; count is
//   $clog2(STABLE_FRAMES+1) bits.
// STRUCTURE
//  Shared package video_mode_pkg: mode encodings MODE_NONE/HZ50/HZ60/OTHER and the window
//   bounds 47/53/56/64 (also used by the ADV7511 config sequencer).
//  One sub-module vsync_watchdog: synchroniser, edge detect, 4-clk eval delay and timeout
//   counter. Outputs eval and timeout pulses. Classification, stability counter and FSM stay
//   in this module.
// TESTING (CLK_FREQ_IN=10, TIMEOUT_MS=1 for short sims; ack model responds in 3 clk)
//  1. 8 frames with i_freq=50 -> o_mode=1 and one req pulse on the 8th eval+1; after the
//     handshake, o_locked=1.
//  2. Locked at 50: 3 frames at 63 then back to 50 -> no req, o_mode stays 1.
//  3. Locked at 50: 8 frames at 59 -> o_mode=2, one req, o_locked=0 until ack falls.
//  4. Stop vsync for 10000 clk -> o_mode=0, req raised, FSM ends in SEARCH with o_locked=0.
//  5. 8 frames at i_freq=40 -> o_mode=3 (OTHER). Same with i_freq_valid=0 -> stays NONE, no req.
//  6. Assert reset while o_reconfig_req=1 -> next clk: req=0, o_mode=0, o_locked=0;
//     relock requires 8 fresh frames.

Source files
------------

// File: rtl/video_mode_pkg.sv
// Video mode encodings and frame-rate classification windows, shared between the
// mode tracker and the ADV7511 config sequencer.
package video_mode_pkg;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_HZ50  = 2'd1,
    MODE_HZ60  = 2'd2,
    MODE_OTHER = 2'd3
  } video_mode_t;

  localparam logic [6:0] HZ50_MIN = 7'd47;
  localparam logic [6:0] HZ50_MAX = 7'd53;
  localparam logic [6:0] HZ60_MIN = 7'd56;
  localparam logic [6:0] HZ60_MAX = 7'd64;

  // Window bounds are inclusive; an unmeasurable rate (0 or invalid) is NONE.
  function automatic video_mode_t classify(input logic valid, input logic [6:0] freq);
    if (!valid || freq == 7'd0)                      return MODE_NONE;
    else if (freq >= HZ50_MIN && freq <= HZ50_MAX)   return MODE_HZ50;
    else if (freq >= HZ60_MIN && freq <= HZ60_MAX)   return MODE_HZ60;
    else                                             return MODE_OTHER;
  endfunction

endpackage

// File: rtl/vsync_watchdog.sv
// Synchronises raw vsync, emits a frame-evaluation strobe 4 clk after each rising edge
// and a one-cycle timeout pulse when no edge has been seen for the watchdog period.
module vsync_watchdog #(
  parameter int CLK_FREQ_IN = 148,
  parameter int TIMEOUT_MS  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic i_vsync,
  output logic o_eval,
  output logic o_timeout
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_IN * 1000 * TIMEOUT_MS;
  localparam int WD_W           = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      r_sync;
  logic [3:0]      r_eval_dly;
  logic [WD_W-1:0] r_wd;
  logic            w_edge;

  assign w_edge    = (r_sync == 2'b01);
  assign o_eval    = r_eval_dly[3];
  // Fires on the cycle the counter steps onto its terminal value, then stays quiet.
  assign o_timeout = !w_edge && (r_wd == WD_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= 2'b00;
      r_eval_dly <= 4'b0000;
      r_wd       <= '0;
    end else begin
      r_sync     <= {r_sync[0], i_vsync};
      r_eval_dly <= {r_eval_dly[2:0], w_edge};
      if (w_edge)
        r_wd <= '0;
      else if (r_wd != WD_TERM)
        r_wd <= r_wd + 1'b1;
    end
  end

endmodule

// File: rtl/video_mode_tracker.sv
// Classifies the per-frame rate, debounces it over STABLE_FRAMES frames and commits
// mode changes to the config sequencer through a 4-phase req/ack handshake.
module video_mode_tracker
  import video_mode_pkg::*;
#(
  parameter int CLK_FREQ_IN   = 148,
  parameter int STABLE_FRAMES = 8,
  parameter int TIMEOUT_MS    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_vsync,
  input  logic [6:0] i_freq,
  input  logic       i_freq_valid,
  input  logic       i_reconfig_ack,
  output logic [1:0] o_mode,
  output logic       o_locked,
  output logic       o_reconfig_req
);

  localparam int CNT_W = $clog2(STABLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_LOCKED,
    ST_REQ,
    ST_ACK_LOW
  } state_t;

  logic             w_eval;
  logic             w_timeout;
  video_mode_t      w_class;
  logic             w_stable;
  video_mode_t      r_cand;
  logic [CNT_W-1:0] r_count;
  state_t           r_state;
  state_t           w_state_next;
  video_mode_t      r_mode;
  video_mode_t      w_mode_next;

  vsync_watchdog #(
    .CLK_FREQ_IN (CLK_FREQ_IN),
    .TIMEOUT_MS  (TIMEOUT_MS)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_vsync   (i_vsync),
    .o_eval    (w_eval),
    .o_timeout (w_timeout)
  );

  assign w_class  = classify(i_freq_valid, i_freq);
  assign w_stable = (r_count == STABLE_CNT);

  // Lost vsync forces an immediately-stable NONE candidate, overriding a same-cycle eval.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand  <= MODE_NONE;
      r_count <= '0;
    end else if (w_timeout) begin
      r_cand  <= MODE_NONE;
      r_count <= STABLE_CNT;
    end else if (w_eval) begin
      if (w_class == r_cand) begin
        if (r_count != STABLE_CNT)
          r_count <= r_count + 1'b1;
      end else begin
        r_cand  <= w_class;
        r_count <= CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_SEARCH;
      r_mode  <= MODE_NONE;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
    end
  end

  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    case (r_state)
      ST_SEARCH: begin
        if (w_stable && r_cand != MODE_NONE) begin
          w_mode_next  = r_cand;
          w_state_next = ST_REQ;
        end
      end
      ST_LOCKED: begin
        if (w_stable && r_cand != r_mode) begin
          w_mode_next  = r_cand;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_reconfig_ack)
          w_state_next = ST_ACK_LOW;
      end
      ST_ACK_LOW: begin
        if (!i_reconfig_ack)
          w_state_next = (r_mode == MODE_NONE) ? ST_SEARCH : ST_LOCKED;
      end
      default: w_state_next = ST_SEARCH;
    endcase
  end

  assign o_mode         = r_mode;
  assign o_locked       = (r_state == ST_LOCKED);
  assign o_reconfig_req = (r_state == ST_REQ);

endmodule

// File: tb/tb_video_mode_tracker.sv
// Directed bench for video_mode_tracker with a 3-clk acknowledge model on the handshake.
module tb_video_mode_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_vsync;
  logic [6:0] i_freq;
  logic       i_freq_valid;
  logic       i_reconfig_ack;
  logic [1:0] o_mode;
  logic       o_locked;
  logic       o_reconfig_req;

  int   checks    = 0;
  int   failures  = 0;
  int   req_rises = 0;
  int   req_high  = 0;
  logic req_prev  = 1'b0;
  logic force_ack = 1'b0;
  logic [2:0] ack_pipe;

  always #5 clk = ~clk;

  video_mode_tracker #(
    .CLK_FREQ_IN   (10),
    .STABLE_FRAMES (8),
    .TIMEOUT_MS    (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_vsync        (i_vsync),
    .i_freq         (i_freq),
    .i_freq_valid   (i_freq_valid),
    .i_reconfig_ack (i_reconfig_ack),
    .o_mode         (o_mode),
    .o_locked       (o_locked),
    .o_reconfig_req (o_reconfig_req)
  );

  // Config sequencer model: ack follows req three clocks later; force_ack pins it high.
  initial begin
    ack_pipe       = 3'b000;
    i_reconfig_ack = 1'b0;
    forever begin
      @(negedge clk);
      ack_pipe       = {ack_pipe[1:0], o_reconfig_req};
      i_reconfig_ack = ack_pipe[2] | force_ack;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (o_reconfig_req && !req_prev) req_rises++;
      if (o_reconfig_req) req_high++;
      req_prev = o_reconfig_req;
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    i_vsync = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame_start(input logic [6:0] f, input logic v);
    i_freq       = f;
    i_freq_valid = v;
    i_vsync      = 1'b1;
    repeat (2) @(negedge clk);
    i_vsync = 1'b0;
  endtask

  task automatic frame(input logic [6:0] f, input logic v);
    frame_start(f, v);
    repeat (30) @(negedge clk);
  endtask

  task automatic frames(input int n, input logic [6:0] f, input logic v);
    for (int i = 0; i < n; i++) frame(f, v);
  endtask

  task automatic wait_req(input logic level, input string name);
    int n = 0;
    while (o_reconfig_req !== level && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_reconfig_req !== level) begin
      failures++;
      $display("FAIL %s req=%0b required=%0b (timed out)", name, o_reconfig_req, level);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] m, input logic l, input logic r);
    checks++;
    if (o_mode !== m || o_locked !== l || o_reconfig_req !== r) begin
      failures++;
      $display("FAIL %s mode/locked/req=%0d/%0b/%0b required=%0d/%0b/%0b",
               name, o_mode, o_locked, o_reconfig_req, m, l, r);
    end
  endtask

  task automatic test_reset();
    i_freq = 7'd0;
    i_freq_valid = 1'b0;
    do_reset();
    check_state("reset_state", 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_lock50();
    int r0, h0;
    r0 = req_rises;
    h0 = req_high;
    frames(7, 7'd50, 1'b1);
    check_state("lock50_after7", 2'd0, 1'b0, 1'b0);
    frame(7'd50, 1'b1);
    check_state("lock50_after8", 2'd1, 1'b1, 1'b0);
    checks++;
    if (req_rises - r0 !== 1 || req_high - h0 !== 3) begin
      failures++;
      $display("FAIL lock50_req rises=%0d high=%0d required=1/3", req_rises - r0, req_high - h0);
    end
  endtask

  task automatic test_jitter();
    int r0;
    r0 = req_rises;
    frames(3, 7'd63, 1'b1);
    check_state("jitter_during", 2'd1, 1'b1, 1'b0);
    frames(8, 7'd50, 1'b1);
    check_state("jitter_after", 2'd1, 1'b1, 1'b0);
    checks++;
    if (req_rises - r0 !== 0) begin
      failures++;
      $display("FAIL jitter_noreq rises=%0d required=0", req_rises - r0);
    end
  endtask

  task automatic test_change60();
    int r0;
    r0 = req_rises;
    frames(7, 7'd59, 1'b1);
    check_state("chg60_after7", 2'd1, 1'b1, 1'b0);
    frame_start(7'd59, 1'b1);
    wait_req(1'b1, "chg60_req_rise");
    check_state("chg60_in_req", 2'd2, 1'b0, 1'b1);
    wait_req(1'b0, "chg60_req_fall");
    check_state("chg60_ack_low", 2'd2, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check_state("chg60_locked", 2'd2, 1'b1, 1'b0);
    checks++;
    if (req_rises - r0 !== 1) begin
      failures++;
      $display("FAIL chg60_rises got=%0d required=1", req_rises - r0);
    end
  endtask

  task automatic test_timeout();
    int r0;
    r0 = req_rises;
    repeat (9000) @(negedge clk);
    check_state("wd_before", 2'd2, 1'b1, 1'b0);
    repeat (1200) @(negedge clk);
    check_state("wd_after", 2'd0, 1'b0, 1'b0);
    checks++;
    if (req_rises - r0 !== 1) begin
      failures++;
      $display("FAIL wd_rises got=%0d required=1", req_rises - r0);
    end
  endtask

  task automatic test_other_and_invalid();
    int r0;
    frames(8, 7'd40, 1'b1);
    check_state("other40", 2'd3, 1'b1, 1'b0);
    do_reset();
    r0 = req_rises;
    frames(4, 7'd50, 1'b0);
    frames(4, 7'd0, 1'b1);
    check_state("invalid_none", 2'd0, 1'b0, 1'b0);
    checks++;
    if (req_rises - r0 !== 0) begin
      failures++;
      $display("FAIL invalid_noreq rises=%0d required=0", req_rises - r0);
    end
  endtask

  task automatic test_windows();
    do_reset();
    frames(7, 7'd50, 1'b1);
    frame(7'd54, 1'b1);
    frames(7, 7'd50, 1'b1);
    check_state("win_broken_run", 2'd0, 1'b0, 1'b0);
    frame(7'd50, 1'b1);
    check_state("win_run_done", 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      frame(7'd56, 1'b1);
      frame(7'd64, 1'b1);
    end
    check_state("win_56_64", 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      frame(7'd54, 1'b1);
      frame(7'd55, 1'b1);
      frame(7'd46, 1'b1);
      frame(7'd65, 1'b1);
    end
    check_state("win_outside", 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      frame(7'd47, 1'b1);
      frame(7'd53, 1'b1);
    end
    check_state("win_47_53", 2'd1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int h0;
    do_reset();
    force_ack = 1'b1;
    h0 = req_high;
    frames(8, 7'd50, 1'b1);
    check_state("early_ack_hold", 2'd1, 1'b0, 1'b0);
    checks++;
    if (req_high - h0 !== 1) begin
      failures++;
      $display("FAIL early_ack_width got=%0d required=1", req_high - h0);
    end
    force_ack = 1'b0;
    repeat (10) @(negedge clk);
    check_state("early_ack_release", 2'd1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_handshake();
    do_reset();
    frames(7, 7'd50, 1'b1);
    frame_start(7'd50, 1'b1);
    wait_req(1'b1, "rst_mid_req_rise");
    reset = 1'b1;
    @(negedge clk);
    check_state("rst_mid_cleared", 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    frames(7, 7'd50, 1'b1);
    check_state("rst_mid_relock7", 2'd0, 1'b0, 1'b0);
    frame(7'd50, 1'b1);
    check_state("rst_mid_relock8", 2'd1, 1'b1, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    i_vsync      = 1'b0;
    i_freq       = 7'd0;
    i_freq_valid = 1'b0;
    test_reset();
    test_lock50();
    test_jitter();
    test_change60();
    test_timeout();
    test_other_and_invalid();
    test_windows();
    test_back_to_back();
    test_reset_mid_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
